// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported synchronous memory between instruction fetch
// and the MEM-stage data port, one access outstanding at a time.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_dm,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               owner_q;     // 0 = fetch, 1 = data
  logic               wr_q;        // data access in flight is a write
  logic [CNT_W-1:0]   cnt_q;
  logic [STV_W-1:0]   starve_q;
  logic               if_ready_q;
  logic               dm_ready_q;
  logic [DATA_W-1:0]  if_rdata_q;
  logic [DATA_W-1:0]  dm_rdata_q;

  logic               grant_dm;
  logic               issue;

  // Grant is combinational so the memory sees the request in the same cycle.
  assign grant_dm = dm_req & (~if_req | (starve_q < STARVE_C));
  assign issue    = (state_q == S_IDLE) & ~reset & (if_req | dm_req);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue) begin
      mem_en = 1'b1;
      if (grant_dm) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else begin
        mem_addr  = if_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      starve_q   <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            owner_q <= grant_dm;
            wr_q    <= grant_dm & dm_we;
            cnt_q   <= CNT_W'(1);
            state_q <= S_WAIT;
            // Only data grants that bypass a waiting fetch count toward starvation.
            if (grant_dm && if_req)
              starve_q <= (starve_q == STARVE_C) ? starve_q : starve_q + STV_W'(1);
            else
              starve_q <= '0;
          end
        end
        S_WAIT: begin
          if (cnt_q == LAT_C) begin
            if (owner_q) begin
              if (!wr_q) dm_rdata_q <= mem_rdata;
              dm_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_ready_q <= 1'b1;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if_ready_q <= 1'b0;
          dm_ready_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_ready    = if_ready_q;
  assign dm_ready    = dm_ready_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign stall_if    = if_req & ~if_ready_q;
  assign stall_dm    = dm_req & ~dm_ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter: transaction-level timeline model,
// memory model with fixed read latency, and a ready-driven scoreboard.
module tb_unified_mem_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 64;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_dm;
  logic [1:0]        dbg_state;

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem_arr [1024];
  logic [DATA_W-1:0] ref_mem [1024];
  logic [DATA_W-1:0] pipe [MEM_LAT];
  logic              s_en, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [DATA_W-1:0] v;
      v = {$urandom, $urandom};
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = '0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    s_en    = mem_en;
    s_we    = mem_we;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
  end

  // Read data appears exactly MEM_LAT cycles after the issue cycle; garbage otherwise.
  always @(posedge clk) begin
    #1;
    for (int i = MEM_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = (s_en && !s_we) ? mem_arr[s_addr] : {$urandom, $urandom};
    if (s_en && s_we) mem_arr[s_addr] = s_wdata;
    mem_rdata = pipe[MEM_LAT-1];
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int                done_cyc;
    bit                is_dm;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  int                free_at   = 0;
  int                starve    = 0;
  bit                prev_rst  = 1'b0;
  logic [DATA_W-1:0] last_dm   = '0;

  always @(negedge clk) begin
    exp_t              e;
    bit                gdm, exp_if_rdy, exp_dm_rdy;
    logic              x_en, x_we;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata;

    exp_if_rdy = exp_q.size() > 0 && exp_q[0].done_cyc == cyc && !exp_q[0].is_dm;
    exp_dm_rdy = exp_q.size() > 0 && exp_q[0].done_cyc == cyc &&  exp_q[0].is_dm;
    check("stall_if", 128'(stall_if), 128'(if_req && !exp_if_rdy));
    check("stall_dm", 128'(stall_dm), 128'(dm_req && !exp_dm_rdy));

    // monitor: pop whenever the DUT presents a completion
    if (if_ready || dm_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ready cycle %0d: got if=%0b dm=%0b expected none",
                 cyc, if_ready, dm_ready);
      end else begin
        e = exp_q.pop_front();
        check("ready_cycle", 128'(cyc), 128'(e.done_cyc));
        check("ready_port", 128'({if_ready, dm_ready}), 128'(e.is_dm ? 2'b01 : 2'b10));
        check(e.is_dm ? "dm_rdata" : "if_rdata", 128'(e.is_dm ? dm_rdata : if_rdata),
              128'(e.data));
      end
    end else if (exp_q.size() > 0 && exp_q[0].done_cyc < cyc) begin
      e = exp_q.pop_front();
      tests++; fails++;
      $display("FAIL missing_ready cycle %0d: got none expected %s ready at %0d",
               cyc, e.is_dm ? "dm" : "if", e.done_cyc);
    end

    if (prev_rst) check("rdata_after_reset", 128'({if_rdata, dm_rdata}), 128'(0));

    // issue model: timeline with one access every MEM_LAT+2 cycles
    x_en = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0;
    if (reset) begin
      exp_q.delete();
      free_at = cyc + 1;
      starve  = 0;
      last_dm = '0;
    end else if (cyc >= free_at && (if_req || dm_req)) begin
      gdm     = dm_req && (!if_req || starve < STARVE_MAX);
      starve  = (gdm && if_req) ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
      free_at = cyc + MEM_LAT + 2;
      x_en    = 1'b1;
      e.done_cyc = cyc + MEM_LAT + 1;
      e.is_dm    = gdm;
      if (gdm) begin
        x_we = dm_we; x_addr = dm_addr; x_wdata = dm_wdata;
        if (dm_we) begin
          ref_mem[dm_addr] = dm_wdata;
          e.data = last_dm;
        end else begin
          e.data  = ref_mem[dm_addr];
          last_dm = e.data;
        end
      end else begin
        x_addr = if_addr;
        e.data = ref_mem[if_addr];
      end
      exp_q.push_back(e);
    end
    check("mem_issue", 128'({mem_en, mem_we, mem_addr, mem_wdata}),
          128'({x_en, x_we, x_addr, x_wdata}));
    prev_rst = reset;
  end

  // ---------------- driver tasks ----------------
  localparam int WAIT_LIMIT = 200;

  task automatic drive_if(input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      int gap, w;
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        if_req = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      if_req  = 1'b1;
      if_addr = ADDR_W'($urandom_range(0, 31));
      w = 0;
      forever begin
        @(negedge clk);
        if (if_ready) break;
        w++;
        if (w > WAIT_LIMIT) begin
          tests++; fails++;
          $display("FAIL if_wait_timeout cycle %0d: got no if_ready expected within %0d",
                   cyc, WAIT_LIMIT);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;
  endtask

  task automatic drive_dm(input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      int gap, w;
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        dm_req = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      dm_req   = 1'b1;
      dm_we    = ($urandom_range(0, 2) == 0);
      dm_addr  = ADDR_W'($urandom_range(0, 31));
      dm_wdata = {$urandom, $urandom};
      w = 0;
      forever begin
        @(negedge clk);
        if (dm_ready) break;
        w++;
        if (w > WAIT_LIMIT) begin
          tests++; fails++;
          $display("FAIL dm_wait_timeout cycle %0d: got no dm_ready expected within %0d",
                   cyc, WAIT_LIMIT);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    dm_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset    = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    fork
      begin
        drive_if(25, 0);
        drive_if(60, 4);
      end
      begin
        drive_dm(60, 0);
        drive_dm(120, 3);
      end
      begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) begin
          repeat ($urandom_range(30, 120)) @(posedge clk);
          #1 reset = 1'b1;
          @(posedge clk);
          #1 reset = 1'b0;
        end
      end
    join
    repeat (MEM_LAT + 4) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before 400000 time units");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
